bio_hdx_link: RTL and testbench

- Half-duplex single-wire serial initiator that drives the shared tri-state pad from the other side: it supplies the pad's enable and data-in, and reads the pad's data-out.
- Per transaction it transmits one request byte, releases the wire, then receives one response byte from the far-end device or reports a timeout.
- Sits between user logic (valid/ready byte interface) and the bidirectional pad instance.

---
 rtl/bio_hdx_link.sv | 204 ++++++++++++++++++++
 tb/tb_bio_hdx_link.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bio_hdx_link.sv
// Half-duplex single-wire initiator: sends a request byte, then releases the wire and receives a response byte.
// Define BIO_HDX_PARITY_EN to add an even-parity bit after the data bits in both directions.
module bio_hdx_link #(
  parameter int unsigned BIT_CYCLES   = 16,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_timeout,
  output logic       rx_frame_err,
  output logic       bus_oe,
  output logic       bus_out,
  input  logic       bus_in
);

`ifdef BIO_HDX_PARITY_EN
  localparam int unsigned NBITS = 9;
`else
  localparam int unsigned NBITS = 8;
`endif
  localparam int unsigned LIMIT = TIMEOUT_BITS * BIT_CYCLES;
  localparam int unsigned CMAX  = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CW    = $clog2(CMAX);
  localparam int unsigned TW    = $clog2(LIMIT + 1);
  localparam int unsigned IW    = $clog2(NBITS);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TURN, RX_WAIT, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [NBITS-1:0] tx_shift;
  logic [NBITS-1:0] rx_shift;
  logic [TW-1:0]    tcnt;
  logic             s1, s2, s3;
  logic             bit_end, fall, par_ok;

  always_comb begin
    bit_end = (cnt == CW'(BIT_CYCLES - 1));
    fall    = s3 & ~s2;
`ifdef BIO_HDX_PARITY_EN
    par_ok  = (rx_shift[8] == ^rx_shift[7:0]);
`else
    par_ok  = 1'b1;
`endif
  end

  // s3 is the previous synchronized level, used only for falling-edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      tcnt         <= '0;
      tx_ready     <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_timeout   <= 1'b0;
      rx_frame_err <= 1'b0;
      bus_oe       <= 1'b0;
      bus_out      <= 1'b1;
    end else begin
      rx_valid     <= 1'b0;
      rx_timeout   <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // ready returns one cycle after the result pulse
          if (!tx_ready) begin
            tx_ready <= 1'b1;
          end else if (tx_valid) begin
`ifdef BIO_HDX_PARITY_EN
            tx_shift <= {^tx_data, tx_data};
`else
            tx_shift <= tx_data;
`endif
            tx_ready <= 1'b0;
            bus_oe   <= 1'b1;
            bus_out  <= 1'b0;
            cnt      <= '0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt      <= '0;
            bit_idx  <= '0;
            bus_out  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            state    <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == IW'(NBITS - 1)) begin
              bus_out <= 1'b1;
              state   <= TX_STOP;
            end else begin
              bus_out  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              bit_idx  <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt     <= '0;
            bus_oe  <= 1'b0;
            bus_out <= 1'b1;
            state   <= TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TURN: begin
          if (cnt == CW'(GUARD_CYCLES - 1)) begin
            tcnt  <= '0;
            state <= RX_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (fall) begin
            cnt   <= '0;
            state <= RX_START;
          end else if (tcnt >= TW'(LIMIT - 1)) begin
            rx_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RX_START: begin
          // a start bit no longer low at its midpoint is a glitch; tcnt keeps its value
          if (cnt == CW'(BIT_CYCLES / 2 - 1)) begin
            cnt <= '0;
            if (!s2) begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              state <= RX_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt      <= '0;
            rx_shift <= {s2, rx_shift[NBITS-1:1]};
            if (bit_idx == IW'(NBITS - 1)) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (s2 && par_ok) begin
              rx_data  <= rx_shift[7:0];
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bio_hdx_link.sv
// Self-checking bench for bio_hdx_link: far-end device model drives response frames on the shared wire.
module tb_bio_hdx_link;
  localparam int BC = 16;
  localparam int GC = 2;
  localparam int TO = 32;
`ifdef BIO_HDX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int M_OK = 0, M_NONE = 1, M_BADSTOP = 2, M_GLITCH = 3, M_BADPAR = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, rx_timeout, rx_frame_err, bus_oe, bus_out, bus_in;
  logic [7:0] rx_data;
  logic       dev_drive = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_rx = '0;

  assign bus_in = bus_oe ? bus_out : dev_drive;

  always #5 sys_clk = ~sys_clk;

  bio_hdx_link #(.BIT_CYCLES(BC), .GUARD_CYCLES(GC), .TIMEOUT_BITS(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_timeout(rx_timeout),
    .rx_frame_err(rx_frame_err), .bus_oe(bus_oe), .bus_out(bus_out), .bus_in(bus_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a frame carrying byte b: start, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (FB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int dev_start(input int mode);
    return (mode == M_GLITCH) ? 53 : 10;
  endfunction

  // Wire level the far-end device drives k cycles after the initiator releases it.
  function automatic logic dev_level(input int mode, input logic [7:0] r, input int k);
    int   i;
    logic v;
    if (mode == M_NONE) return 1'b1;
    if (mode == M_GLITCH && k >= 10 && k < 13) return 1'b0;
    if (k < dev_start(mode)) return 1'b1;
    i = (k - dev_start(mode)) / BC;
    if (i >= FB) return 1'b1;
    v = frame_bit(r, i);
    if (mode == M_BADSTOP && i == FB - 1) v = 1'b0;
    if (mode == M_BADPAR && i == 9) v = ~v;
    return v;
  endfunction

  task automatic txn(input logic [7:0] b, input int mode, input logic [7:0] r);
    int c, oe_cycles, bit_errs, k, pk, pkind, npulses, oe_late, endk, fend, waitn, exp_kind;
    logic [7:0] data_at, exp_data;
    logic rdy_at, rdy_after;
    waitn = 0;
    while (tx_ready !== 1'b1 && waitn < 20) begin
      @(negedge sys_clk);
      waitn++;
    end
    check("ready_before_req", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    oe_cycles = 0; bit_errs = 0; c = 0;
    while (bus_oe === 1'b1 && c < 400) begin
      if (bus_out !== frame_bit(b, c / BC)) bit_errs++;
      oe_cycles++;
      c++;
      @(negedge sys_clk);
    end
    check("tx_oe_cycles", oe_cycles, FB * BC);
    check("tx_bit_errors", bit_errs, 0);

    fend = (mode == M_NONE) ? 0 : dev_start(mode) + FB * BC + 2;
    pk = -1; pkind = -1; npulses = 0; oe_late = 0; endk = 800;
    data_at = '0; rdy_at = 1'b1; rdy_after = 1'b0;
    k = 0;
    while (k < endk) begin
      if (bus_oe !== 1'b0) oe_late++;
      npulses += int'(rx_valid) + int'(rx_timeout) + int'(rx_frame_err);
      if (pk < 0 && (rx_valid || rx_timeout || rx_frame_err)) begin
        pk      = k;
        pkind   = rx_valid ? 0 : (rx_timeout ? 1 : 2);
        data_at = rx_data;
        rdy_at  = tx_ready;
        endk    = (pk + 2 > fend) ? pk + 2 : fend;
      end
      if (pk >= 0 && k == pk + 1) rdy_after = tx_ready;
      dev_drive = dev_level(mode, r, k);
      @(negedge sys_clk);
      k++;
    end
    dev_drive = 1'b1;

    exp_kind = (mode == M_OK || mode == M_GLITCH) ? 0 : (mode == M_NONE) ? 1 : 2;
    exp_data = (exp_kind == 0) ? r : model_rx;
    model_rx = exp_data;
    check("result_seen", (pk >= 0), 1);
    check("result_kind", pkind, exp_kind);
    check("pulse_count", npulses, 1);
    check("rx_data", data_at, exp_data);
    check("ready_low_at_pulse", rdy_at, 0);
    check("ready_after_pulse", rdy_after, 1);
    check("oe_low_during_rx", oe_late, 0);
    if (mode == M_NONE)
      check("timeout_cycle_window", (pk >= GC + TO * BC - 2) && (pk <= GC + TO * BC + 2), 1);
  endtask

  initial begin
    int np, noe;
    int modes[$];
    modes = '{M_OK, M_BADSTOP, M_GLITCH};
`ifdef BIO_HDX_PARITY_EN
    modes.push_back(M_BADPAR);
`endif
    repeat (3) @(negedge sys_clk);
    check("reset_bus_oe", bus_oe, 0);
    check("reset_bus_out", bus_out, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_data", rx_data, 0);
    check("reset_pulses", {rx_valid, rx_timeout, rx_frame_err}, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_bus_oe", bus_oe, 0);

    txn(8'hA5, M_OK, 8'h3C);
    txn(8'hA5, M_NONE, 8'h00);
    txn(8'($urandom), M_BADSTOP, 8'h55);
    txn(8'($urandom), M_GLITCH, 8'h81);

    // reset asserted in the middle of the data bits
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge sys_clk);
    check("midreset_driving", bus_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    model_rx = '0;
    check("midreset_oe_async", bus_oe, 0);
    check("midreset_out", bus_out, 1);
    check("midreset_ready", tx_ready, 1);
    check("midreset_rx_data", rx_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    np = 0; noe = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      np  += int'(rx_valid) + int'(rx_timeout) + int'(rx_frame_err);
      noe += int'(bus_oe);
    end
    check("postreset_pulses", np, 0);
    check("postreset_oe", noe, 0);
    check("postreset_ready", tx_ready, 1);
    txn(8'h0F, M_OK, 8'($urandom));
`ifdef BIO_HDX_PARITY_EN
    txn(8'($urandom), M_BADPAR, 8'h6B);
`endif

    for (int n = 0; n < 8; n++)
      txn(8'($urandom), modes[$urandom_range(0, modes.size() - 1)], 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
